// File: rtl/sig_seq_driver.sv
// Table-driven {d,c,b,a} pattern sequencer with an embedded registered checker
// that counts cycles where (a||b) or (c||d) is false while playing.
module sig_seq_driver #(
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [3:0]               wr_vec,
  input  logic [HOLD_W-1:0]        wr_hold,
  input  logic [$clog2(DEPTH):0]   num_entries,
  input  logic                     loop,
  input  logic                     start,
  input  logic                     stop,
  output logic [3:0]               vec_out,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] entry_idx,
  output logic [CNT_W-1:0]         viol_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      DEPTH_N  = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] VIOL_MAX = {CNT_W{1'b1}};

  typedef enum logic {IDLE, PLAY} state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     idx_reg, idx_next;
  logic [AW-1:0]     last_reg, last_next;
  logic              loop_reg, loop_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [3:0]        vec_reg, vec_next;
  logic              done_reg, done_next;
  logic [CNT_W-1:0]  viol_reg, viol_next;

  // Table is read asynchronously so an entry can be driven on the same edge
  // it is selected, including back-to-back hold=1 entries.
  logic [3:0]        mem_vec  [DEPTH];
  logic [HOLD_W-1:0] mem_hold [DEPTH];

  logic [AW-1:0]     idx_inc;
  logic [AW:0]       n_eff;
  logic              vec_fail;

  function automatic logic [HOLD_W-1:0] hold_load(input logic [HOLD_W-1:0] h);
    return (h == '0) ? '0 : h - HOLD_W'(1);
  endfunction

  assign idx_inc  = idx_reg + AW'(1);
  assign n_eff    = (num_entries > DEPTH_N) ? DEPTH_N : num_entries;
  assign vec_fail = !(vec_reg[0] | vec_reg[1]) || !(vec_reg[2] | vec_reg[3]);

  always_ff @(posedge clk) begin
    if (wr_en && state_reg == IDLE) begin
      mem_vec[wr_addr]  <= wr_vec;
      mem_hold[wr_addr] <= wr_hold;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      last_reg     <= '0;
      loop_reg     <= 1'b0;
      hold_cnt_reg <= '0;
      vec_reg      <= '0;
      done_reg     <= 1'b0;
      viol_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      last_reg     <= last_next;
      loop_reg     <= loop_next;
      hold_cnt_reg <= hold_cnt_next;
      vec_reg      <= vec_next;
      done_reg     <= done_next;
      viol_reg     <= viol_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    last_next     = last_reg;
    loop_next     = loop_reg;
    hold_cnt_next = hold_cnt_reg;
    vec_next      = vec_reg;
    done_next     = 1'b0;
    viol_next     = viol_reg;

    // hold_cnt_reg holds the remaining cycles after the current one
    if (state_reg == PLAY && vec_fail && viol_reg != VIOL_MAX)
      viol_next = viol_reg + CNT_W'(1);

    case (state_reg)
      IDLE: begin
        if (start && !stop && n_eff != '0) begin
          state_next    = PLAY;
          idx_next      = '0;
          last_next     = AW'(n_eff - (AW+1)'(1));
          loop_next     = loop;
          vec_next      = mem_vec[0];
          hold_cnt_next = hold_load(mem_hold[0]);
          viol_next     = '0;
        end
      end
      PLAY: begin
        if (stop) begin
          state_next = IDLE;
          vec_next   = '0;
          idx_next   = '0;
        end else if (hold_cnt_reg != '0) begin
          hold_cnt_next = hold_cnt_reg - HOLD_W'(1);
        end else if (idx_reg != last_reg) begin
          idx_next      = idx_inc;
          vec_next      = mem_vec[idx_inc];
          hold_cnt_next = hold_load(mem_hold[idx_inc]);
        end else if (loop_reg) begin
          idx_next      = '0;
          vec_next      = mem_vec[0];
          hold_cnt_next = hold_load(mem_hold[0]);
        end else begin
          state_next = IDLE;
          vec_next   = '0;
          idx_next   = '0;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign vec_out   = vec_reg;
  assign busy      = (state_reg == PLAY);
  assign done      = done_reg;
  assign entry_idx = idx_reg;
  assign viol_cnt  = viol_reg;

endmodule
